key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entry count; legal values 2, 4, 8, 16.
REQ-002 Port: clock  input  1  system clock; all state changes on posedge.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: key_pulse  input  4  per-key pulses from upstream key detectors; bit i high for one or more cycles per press.
REQ-005 Port: evt_valid  output  1  head entry available.
REQ-006 Port: evt_code  output  2  key index of head entry; valid only while evt_valid=1.
REQ-007 Port: evt_ready  input  1  consumer accepts head entry this cycle.
REQ-008 Port: full  output  1  FIFO holds DEPTH entries.
REQ-009 Port: overflow  output  1  sticky flag: at least one press dropped since reset.

Function
REQ-010 The block SHALL register key_pulse into key_prev each cycle; a press on key i is an edge: key_pulse[i]=1 and key_prev[i]=0 at a clock edge.
REQ-011 Each edge SHALL set pending[i] at that clock edge; a pulse held high for multiple cycles yields exactly one edge.
REQ-012 An edge on key i while pending[i]=1 and pending[i] is not being cleared that cycle SHALL be dropped and SHALL set overflow.
REQ-013 An edge on key i in the same cycle pending[i] is cleared by a push SHALL leave pending[i]=1; no drop.
REQ-014 Arbiter: each cycle with any pending bit set and a push permitted, the block SHALL push the lowest-index pending key and clear only that bit; at most one push per cycle.
REQ-015 Push permitted when count<DEPTH, or count=DEPTH and a pop occurs in the same cycle.
REQ-016 Pop occurs when evt_valid=1 and evt_ready=1; evt_ready while evt_valid=0 SHALL have no effect.
REQ-017 evt_valid SHALL equal (count!=0); evt_code SHALL equal the head entry directly from registers, no combinational path from key_pulse or evt_ready.
REQ-018 Latency: edge sampled at clock edge k on an empty queue with no other pending SHALL give evt_valid=1 after clock edge k+1.
REQ-019 Order: entries SHALL pop in push order; read/write pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push on empty with no pop SHALL not forward combinationally.
REQ-021 full SHALL equal (count=DEPTH), registered-state derived.
REQ-022 While full with no pop, pending bits SHALL hold (not dropped) until space frees; only REQ-012 drops.

Reset
REQ-023 resetn=0 at a clock edge SHALL clear key_prev, pending, pointers, count, overflow (and ovf_count if present), aborting any queued or pending events.
REQ-024 After reset, evt_valid=0, evt_code=0, full=0, overflow=0.
REQ-025 key_prev clears to 0, so key_pulse held high across reset release SHALL produce one edge at the first non-reset clock edge.

Configuration
REQ-026 Macro KEY_EVENT_QUEUE_OVF_CNT_EN defined: extra port ovf_count  output  8  count of cycles in which at least one press was dropped, saturating at 255, reset 0.
REQ-027 Macro undefined: no ovf_count port or counter; all other behaviour identical.

Verification
REQ-028 Reset, key_pulse=4'b0010 for 5 cycles, evt_ready=0 -> evt_valid=1 two edges after first high sample, evt_code=1, exactly one entry (count=1).
REQ-029 key_pulse=4'b1011 one cycle, evt_ready=1 -> three pops in order codes 0,1,3, no overflow.
REQ-030 DEPTH=4, evt_ready=0, five separate presses on keys 0,1,2,3,0 -> full=1 after 4 pushes, pending[0] holds; raise evt_ready -> fifth event code 0 delivered last, overflow=0.
REQ-031 Queue full, pending[2]=1, new press on key 2 -> overflow=1; with KEY_EVENT_QUEUE_OVF_CNT_EN ovf_count=1.
REQ-032 Full queue, evt_ready=1 and pending[1]=1 same cycle -> simultaneous pop and push, count stays 4, full stays 1.
REQ-033 Queue with 3 entries, resetn=0 one cycle -> evt_valid=0, count=0, overflow=0 next cycle.

Source files
------------

// File: rtl/key_event_queue.sv
// Key press event queue: edge-detects four key pulse lines and queues key indices in a DEPTH-entry FIFO.
// Define KEY_EVENT_QUEUE_OVF_CNT_EN to add the saturating ovf_count port.
module key_event_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] key_pulse,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       full,
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
    output logic [7:0] ovf_count,
`endif
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [3:0]    r_key_prev;
    logic [3:0]    r_pending;
    logic [1:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [3:0]    w_edge;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_any;
    logic [1:0]    w_code;
    logic          w_push;
    logic [3:0]    w_clr;
    logic [3:0]    w_drop;

    assign w_edge    = key_pulse & ~r_key_prev;
    assign w_pop     = (r_count != '0) && evt_ready;
    assign w_push_ok = (r_count != FULL_CNT) || w_pop;

    // Lowest pending index wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        w_any  = 1'b0;
        w_code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_any  = 1'b1;
                w_code = 2'(i);
            end
        end
    end

    assign w_push = w_any && w_push_ok;
    assign w_clr  = w_push ? (4'b0001 << w_code) : 4'b0000;
    // A bit being granted this cycle can absorb a new edge without loss.
    assign w_drop = w_edge & r_pending & ~w_clr;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_key_prev <= 4'b0000;
            r_pending  <= 4'b0000;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'd0;
        end else begin
            r_key_prev <= key_pulse;
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            if (|w_drop) r_overflow <= 1'b1;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clock) begin
        if (!resetn)
            r_ovf_cnt <= 8'd0;
        else if ((|w_drop) && (r_ovf_cnt != 8'hFF))
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end

    assign ovf_count = r_ovf_cnt;
`endif

    assign evt_valid = (r_count != '0);
    assign evt_code  = r_mem[r_rd_ptr];
    assign full      = (r_count == FULL_CNT);
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (DEPTH=4): per-cycle vector table plus hand sequences
// for overflow, full-queue push/pop and reset behaviour.
module tb_key_event_queue;
    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] key_pulse;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       full;
    logic       overflow;
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    key_event_queue #(.DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .key_pulse (key_pulse),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .full      (full),
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
        .ovf_count (ovf_count),
`endif
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rstn;
        logic [3:0] kp;
        logic       rdy;
        logic       ev;
        logic       cc;     // compare evt_code on this row
        logic [1:0] code;
        logic       fu;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs ahead of the edge, sample 1ns after it.
    task automatic step(input logic rstn, input logic [3:0] kp, input logic rdy);
        resetn    = rstn;
        key_pulse = kp;
        evt_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic cc,
                              input logic [1:0] code, input logic fu, input logic ov);
        chk({tag, ".evt_valid"}, int'(evt_valid), int'(ev));
        if (cc) chk({tag, ".evt_code"}, int'(evt_code), int'(code));
        chk({tag, ".full"}, int'(full), int'(fu));
        chk({tag, ".overflow"}, int'(overflow), int'(ov));
    endtask

    task automatic add(input logic rstn, input logic [3:0] kp, input logic rdy, input logic ev,
                       input logic cc, input logic [1:0] code, input logic fu, input logic ov);
        vec_t v;
        v.rstn = rstn; v.kp = kp; v.rdy = rdy; v.ev = ev;
        v.cc = cc; v.code = code; v.fu = fu; v.ov = ov;
        tbl.push_back(v);
    endtask

    initial begin
        resetn    = 1'b0;
        key_pulse = 4'b0000;
        evt_ready = 1'b0;

        // rstn kp rdy | valid cc code full ovf
        add(0, 4'b0000, 0, 0, 1, 0, 0, 0);   // reset state, code 0
        add(1, 4'b0010, 0, 0, 0, 0, 0, 0);   // edge on key1 sets pending
        add(1, 4'b0010, 0, 1, 1, 1, 0, 0);   // pushed: valid two edges after first sample
        add(1, 4'b0010, 0, 1, 1, 1, 0, 0);   // held pulse: no second edge
        add(1, 4'b0010, 0, 1, 1, 1, 0, 0);
        add(1, 4'b0010, 0, 1, 1, 1, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0, 0);   // one pop empties: exactly one entry
        add(1, 4'b1011, 1, 0, 0, 0, 0, 0);   // three edges; ready with empty queue ignored
        add(1, 4'b0000, 1, 1, 1, 0, 0, 0);
        add(1, 4'b0000, 1, 1, 1, 1, 0, 0);
        add(1, 4'b0000, 1, 1, 1, 3, 0, 0);
        add(1, 4'b0000, 1, 0, 0, 0, 0, 0);
        add(1, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(1, 4'b0001, 0, 0, 0, 0, 0, 0);   // presses 0,1,2,3,0 one per cycle
        add(1, 4'b0010, 0, 1, 1, 0, 0, 0);
        add(1, 4'b0100, 0, 1, 1, 0, 0, 0);
        add(1, 4'b1000, 0, 1, 1, 0, 0, 0);
        add(1, 4'b0001, 0, 1, 1, 0, 1, 0);   // fourth push: full
        add(1, 4'b0000, 0, 1, 1, 0, 1, 0);   // pending[0] held, no drop
        add(1, 4'b0000, 0, 1, 1, 0, 1, 0);
        add(1, 4'b0000, 1, 1, 1, 1, 1, 0);   // pop+push while full: stays full
        add(1, 4'b0000, 1, 1, 1, 2, 0, 0);
        add(1, 4'b0000, 1, 1, 1, 3, 0, 0);
        add(1, 4'b0000, 1, 1, 1, 0, 0, 0);   // fifth press delivered last
        add(1, 4'b0000, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rstn, tbl[i].kp, tbl[i].rdy);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].cc, tbl[i].code, tbl[i].fu, tbl[i].ov);
        end
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
        chk("vec.ovf_count", int'(ovf_count), 0);
`endif

        // Fill with 0,1,2,3 leaving pending[2], then re-press key 2 while full.
        step(0, 4'b0000, 0);
        expect_out("ovf.reset", 0, 1, 0, 0, 0);
        step(1, 4'b0001, 0);
        step(1, 4'b0010, 0);
        step(1, 4'b0100, 0);
        step(1, 4'b1000, 0);
        step(1, 4'b0100, 0);
        expect_out("ovf.filled", 1, 1, 0, 1, 0);
        step(1, 4'b0000, 0);
        expect_out("ovf.hold", 1, 1, 0, 1, 0);
        step(1, 4'b0100, 0);
        expect_out("ovf.drop", 1, 1, 0, 1, 1);
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
        chk("ovf.ovf_count", int'(ovf_count), 1);
`endif
        step(1, 4'b0000, 0);
        expect_out("ovf.sticky", 1, 1, 0, 1, 1);

        // pending becomes {1,2}; pop and push together on a full queue.
        step(1, 4'b0010, 0);
        expect_out("pp.press1", 1, 1, 0, 1, 1);
        step(1, 4'b0000, 1);
        expect_out("pp.swap", 1, 1, 1, 1, 1);
        step(1, 4'b0000, 1);
        expect_out("pp.swap2", 1, 1, 2, 1, 1);
        step(1, 4'b0000, 1);
        expect_out("pp.drain3", 1, 1, 3, 0, 1);
        step(1, 4'b0000, 1);
        expect_out("pp.drain1", 1, 1, 1, 0, 1);
        step(1, 4'b0000, 1);
        expect_out("pp.drain2", 1, 1, 2, 0, 1);
        step(1, 4'b0000, 1);
        expect_out("pp.empty", 0, 0, 0, 0, 1);
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
        chk("pp.ovf_count", int'(ovf_count), 1);
`endif

        // Three entries queued, then a one-cycle reset with key 0 held across release.
        step(1, 4'b0111, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        expect_out("rst.three", 1, 1, 0, 0, 1);
        step(0, 4'b0001, 0);
        expect_out("rst.cleared", 0, 1, 0, 0, 0);
`ifdef KEY_EVENT_QUEUE_OVF_CNT_EN
        chk("rst.ovf_count", int'(ovf_count), 0);
`endif
        step(1, 4'b0001, 0);
        expect_out("rst.edge", 0, 0, 0, 0, 0);
        step(1, 4'b0001, 0);
        expect_out("rst.push", 1, 1, 0, 0, 0);
        step(1, 4'b0001, 1);
        expect_out("rst.pop", 0, 0, 0, 0, 0);
        step(1, 4'b0001, 1);
        expect_out("rst.noedge", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
